// File: rtl/prbs26_checker.sv
// PRBS-26 receive checker: self-synchronises to the 26-bit Galois LFSR stream.
// In HUNT it fills a history register from the received bits. It locks after
// LOCK_CNT consecutive correct predictions. In LOCKED it flywheels on its own
// prediction, counts mismatches, and drops back to HUNT when one observation
// window collects LOSS_THRESH errors.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// ST_HUNT   | filling history / counting consecutive correct predictions
// ST_LOCKED | flywheel prediction, error counting, loss-of-lock window
module prbs26_checker #(
  parameter int LOCK_CNT    = 32,
  parameter int WIN         = 256,
  parameter int LOSS_THRESH = 16,
  parameter int CNT_W       = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             din,
  input  logic             din_valid,
  input  logic             clr_cnt,
  output logic             locked,
  output logic             err_pulse,
  output logic [CNT_W-1:0] err_cnt,
  output logic [CNT_W-1:0] bit_cnt
);

  localparam logic [0:0] ST_HUNT   = 1'b0;
  localparam logic [0:0] ST_LOCKED = 1'b1;

  localparam int MR_W = $clog2(LOCK_CNT + 1);
  localparam int WB_W = $clog2(WIN);
  localparam int WE_W = $clog2(LOSS_THRESH + 1);

  // hist_q[1] is the newest bit, hist_q[26] the oldest
  logic [0:0]       state_q, state_d;
  logic [26:1]      hist_q, hist_d;
  logic [4:0]       fill_q, fill_d;
  logic [MR_W-1:0]  match_run_q, match_run_d;
  logic [WB_W-1:0]  win_bits_q, win_bits_d;
  logic [WE_W-1:0]  win_errs_q, win_errs_d;
  logic             err_pulse_q, err_pulse_d;
  logic [CNT_W-1:0] err_cnt_q, err_cnt_d;
  logic [CNT_W-1:0] bit_cnt_q, bit_cnt_d;

  logic             pred;
  logic             err;
  logic [26:1]      hist_fly;
  logic [MR_W-1:0]  mr_plus;
  logic [WB_W:0]    wb_plus;
  logic [WE_W:0]    errs_plus;

  // Prediction from the recurrence y[n] = y[n-18]^y[n-19]^y[n-25]^y[n-26]
  always_comb begin
    pred      = hist_q[18] ^ hist_q[19] ^ hist_q[25] ^ hist_q[26];
    err       = din ^ pred;
    hist_fly  = {hist_q[25:1], pred};
    mr_plus   = match_run_q + MR_W'(1);
    wb_plus   = {1'b0, win_bits_q} + (WB_W+1)'(1);
    errs_plus = {1'b0, win_errs_q} + (WE_W+1)'(err);
  end

  // Next-state logic: HUNT acquisition, LOCKED flywheel checking, counters
  always_comb begin
    state_d     = state_q;
    hist_d      = hist_q;
    fill_d      = fill_q;
    match_run_d = match_run_q;
    win_bits_d  = win_bits_q;
    win_errs_d  = win_errs_q;
    err_pulse_d = 1'b0;
    err_cnt_d   = err_cnt_q;
    bit_cnt_d   = bit_cnt_q;

    if (din_valid) begin
      if (state_q == ST_HUNT) begin
        hist_d = {hist_q[25:1], din};
        if (fill_q < 5'd26) begin
          fill_d      = fill_q + 5'd1;
          match_run_d = '0;
        end else if ((din == pred) && (hist_q != '0)) begin
          if (mr_plus == MR_W'(LOCK_CNT)) begin
            state_d     = ST_LOCKED;
            match_run_d = '0;
            win_bits_d  = '0;
            win_errs_d  = '0;
          end else begin
            match_run_d = mr_plus;
          end
        end else begin
          match_run_d = '0;
        end
      end else begin
        // Received bit is never fed back, so one error cannot multiply
        hist_d      = hist_fly;
        err_pulse_d = err;
        if (err && (err_cnt_q != '1)) err_cnt_d = err_cnt_q + CNT_W'(1);
        if (bit_cnt_q != '1) bit_cnt_d = bit_cnt_q + CNT_W'(1);
        if ((errs_plus >= (WE_W+1)'(LOSS_THRESH)) || (hist_fly == '0)) begin
          state_d     = ST_HUNT;
          fill_d      = '0;
          match_run_d = '0;
        end else if (wb_plus == (WB_W+1)'(WIN)) begin
          win_bits_d = '0;
          win_errs_d = '0;
        end else begin
          win_bits_d = wb_plus[WB_W-1:0];
          win_errs_d = errs_plus[WE_W-1:0];
        end
      end
    end

    // Clear wins over any increment on the same cycle
    if (clr_cnt) begin
      err_cnt_d = '0;
      bit_cnt_d = '0;
    end
  end

  // State and counter registers, async active-high reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_HUNT;
      hist_q      <= '0;
      fill_q      <= '0;
      match_run_q <= '0;
      win_bits_q  <= '0;
      win_errs_q  <= '0;
      err_pulse_q <= 1'b0;
      err_cnt_q   <= '0;
      bit_cnt_q   <= '0;
    end else begin
      state_q     <= state_d;
      hist_q      <= hist_d;
      fill_q      <= fill_d;
      match_run_q <= match_run_d;
      win_bits_q  <= win_bits_d;
      win_errs_q  <= win_errs_d;
      err_pulse_q <= err_pulse_d;
      err_cnt_q   <= err_cnt_d;
      bit_cnt_q   <= bit_cnt_d;
    end
  end

  // All outputs come straight from flops
  always_comb begin
    locked    = (state_q == ST_LOCKED);
    err_pulse = err_pulse_q;
    err_cnt   = err_cnt_q;
    bit_cnt   = bit_cnt_q;
  end

endmodule

// File: tb/tb_prbs26_checker.sv
// Directed bench for prbs26_checker: a Galois generator drives the stream,
// expectations are queued at drive time and compared one clock later.
module tb_prbs26_checker;

  localparam int CW = 32;
  localparam int LOCK_BITS = 58;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          din = 1'b0;
  logic          din_valid = 1'b0;
  logic          clr_cnt = 1'b0;
  logic          locked;
  logic          err_pulse;
  logic [CW-1:0] err_cnt;
  logic [CW-1:0] bit_cnt;

  prbs26_checker dut (
    .clk       (clk),
    .rst       (rst),
    .din       (din),
    .din_valid (din_valid),
    .clr_cnt   (clr_cnt),
    .locked    (locked),
    .err_pulse (err_pulse),
    .err_cnt   (err_cnt),
    .bit_cnt   (bit_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    int            idx;
    logic          lck;
    logic          pls;
    logic [CW-1:0] ec;
    logic [CW-1:0] bc;
  } exp_t;

  exp_t sb[$];

  int n_cmp = 0;
  int n_fail = 0;
  int n_step = 0;

  // Generator state s[1:26], output s[26]
  logic [26:1] gs;
  logic        zero_mode = 1'b0;

  // Bench view of the link
  logic          m_locked = 1'b0;
  int            hunt_cnt = 0;
  int            m_wb = 0;
  int            m_we = 0;
  logic [CW-1:0] m_err = '0;
  logic [CW-1:0] m_bits = '0;

  function automatic logic [26:1] gen_next(input logic [26:1] s);
    logic [26:1] n;
    n = {s[25:1], s[26]};
    n[2] = s[1] ^ s[26];
    n[8] = s[7] ^ s[26];
    n[9] = s[8] ^ s[26];
    return n;
  endfunction

  task automatic chk_bit(input string tag, input logic got, input logic want);
    n_cmp++;
    assert (got === want) else begin
      n_fail++;
      $error("FAIL %s: got %b want %b", tag, got, want);
    end
  endtask

  task automatic chk_cnt(input string tag, input logic [CW-1:0] got, input logic [CW-1:0] want);
    n_cmp++;
    assert (got === want) else begin
      n_fail++;
      $error("FAIL %s: got %0d want %0d", tag, got, want);
    end
  endtask

  // One clock: drive, queue expectation, then compare after the edge
  task automatic step(input logic v, input logic flip, input logic c);
    exp_t e;
    logic y;
    y = zero_mode ? 1'b0 : gs[26];
    din = y ^ flip;
    din_valid = v;
    clr_cnt = c;
    e.pls = 1'b0;
    if (v) begin
      if (!zero_mode) gs = gen_next(gs);
      if (!m_locked) begin
        if (!zero_mode) begin
          hunt_cnt++;
          if (hunt_cnt == LOCK_BITS) begin
            m_locked = 1'b1;
            m_wb = 0;
            m_we = 0;
          end
        end
      end else begin
        e.pls = flip;
        if (flip && (m_err != '1)) m_err++;
        if (m_bits != '1) m_bits++;
        if (m_we + int'(flip) >= 16) begin
          m_locked = 1'b0;
          hunt_cnt = 0;
        end else if (m_wb + 1 == 256) begin
          m_wb = 0;
          m_we = 0;
        end else begin
          m_wb++;
          m_we += int'(flip);
        end
      end
    end
    if (c) begin
      m_err = '0;
      m_bits = '0;
    end
    e.idx = n_step;
    e.lck = m_locked;
    e.ec = m_err;
    e.bc = m_bits;
    sb.push_back(e);
    n_step++;
    @(posedge clk);
    #1;
    e = sb.pop_front();
    chk_bit($sformatf("locked@%0d", e.idx), locked, e.lck);
    chk_bit($sformatf("err_pulse@%0d", e.idx), err_pulse, e.pls);
    chk_cnt($sformatf("err_cnt@%0d", e.idx), err_cnt, e.ec);
    chk_cnt($sformatf("bit_cnt@%0d", e.idx), bit_cnt, e.bc);
  endtask

  // Asynchronous reset pulse; outputs must clear before any clock edge
  task automatic do_reset();
    rst = 1'b1;
    #1;
    chk_bit("rst_locked", locked, 1'b0);
    chk_bit("rst_err_pulse", err_pulse, 1'b0);
    chk_cnt("rst_err_cnt", err_cnt, '0);
    chk_cnt("rst_bit_cnt", bit_cnt, '0);
    m_locked = 1'b0;
    hunt_cnt = 0;
    m_err = '0;
    m_bits = '0;
    #1;
    rst = 1'b0;
  endtask

  initial begin
    gs = 26'h0000001;
    // Power-on reset
    @(posedge clk);
    #1;
    do_reset();
    // Clean lock, then a stretch of locked counting
    for (int i = 0; i < LOCK_BITS + 20; i++) step(1'b1, 1'b0, 1'b0);
    chk_bit("clean_locked", locked, 1'b1);
    chk_cnt("clean_bits", bit_cnt, 32'd20);
    // Single flip: one pulse, no multiplication
    step(1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 40; i++) step(1'b1, 1'b0, 1'b0);
    chk_cnt("single_err_cnt", err_cnt, 32'd1);
    chk_bit("single_locked", locked, 1'b1);
    // Loss of lock after 16 errors, then relock
    do_reset();
    for (int i = 0; i < LOCK_BITS + 5; i++) step(1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 16; i++) step(1'b1, 1'b1, 1'b0);
    chk_bit("loss_unlocked", locked, 1'b0);
    chk_cnt("loss_err_cnt", err_cnt, 32'd16);
    for (int i = 0; i < LOCK_BITS + 4; i++) step(1'b1, 1'b0, 1'b0);
    chk_bit("relock", locked, 1'b1);
    // Window rollover: 15 errors in each of two windows
    do_reset();
    for (int i = 0; i < LOCK_BITS; i++) step(1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 600; i++)
      step(1'b1, ((i >= 10 && i < 25) || (i >= 300 && i < 315)), 1'b0);
    chk_bit("roll_locked", locked, 1'b1);
    chk_cnt("roll_err_cnt", err_cnt, 32'd30);
    // All-zero input never locks
    do_reset();
    zero_mode = 1'b1;
    for (int i = 0; i < 1000; i++) step(1'b1, 1'b0, 1'b0);
    zero_mode = 1'b0;
    chk_bit("zero_unlocked", locked, 1'b0);
    // Gapped valid stream
    do_reset();
    for (int i = 0; i < LOCK_BITS + 10; i++) begin
      int gap;
      gap = int'($urandom_range(1, 5));
      for (int g = 0; g < gap; g++) step(1'b0, 1'b0, 1'b0);
      step(1'b1, 1'b0, 1'b0);
    end
    chk_bit("gap_locked", locked, 1'b1);
    chk_cnt("gap_err_cnt", err_cnt, 32'd0);
    chk_cnt("gap_bits", bit_cnt, 32'd10);
    // Clear coincident with an error bit
    step(1'b1, 1'b1, 1'b0);
    step(1'b1, 1'b1, 1'b1);
    chk_bit("clr_pulse", err_pulse, 1'b1);
    chk_cnt("clr_err_cnt", err_cnt, 32'd0);
    for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 1'b0);
    // Reset while locked clears asynchronously
    @(negedge clk);
    do_reset();
    @(posedge clk);
    #1;
    for (int i = 0; i < 10; i++) step(1'b1, 1'b0, 1'b0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/prbs26_checker.md
Name: prbs26_checker

Overview:
- Receive-side partner of the 26-bit Galois LFSR pattern generator. It takes the generator's serial output bit stream and self-synchronises to it.
- It declares lock, then counts bit errors against a flywheel prediction.
- It drops lock when the error density exceeds a threshold.
- It sits at the sink end of the link/BIST path and gives lock status and saturating error/bit counters to software.

Parameters:
LOCK_CNT, 32, consecutive correct predictions needed in HUNT to declare lock (>=1)
WIN, 256, length in valid bits of the loss-of-lock observation window while LOCKED (>=2)
LOSS_THRESH, 16, errors within one window that force return to HUNT (1..WIN)
CNT_W, 32, width of err_cnt and bit_cnt

Ports:
clk  input  1  rising-edge clock
rst  input  1  asynchronous active-high reset
din  input  1  serial PRBS bit; sampled only when din_valid=1
din_valid  input  1  qualifies din; any gap length is allowed
clr_cnt  input  1  synchronous clear of err_cnt and bit_cnt
locked  output  1  1 while in LOCKED state
err_pulse  output  1  one-cycle pulse per mismatching bit while LOCKED
err_cnt  output  CNT_W  saturating count of errors seen while LOCKED
bit_cnt  output  CNT_W  saturating count of valid bits checked while LOCKED

Behaviour:
- Generator stream definition:
  - Generator state s[1:26]; output bit y = s[26] each step.
  - Update: s1'=s26, s2'=s1^s26, s8'=s7^s26, s9'=s8^s26; every other bit takes its lower neighbour.
  - Equivalent output recurrence: y[n] = y[n-18]^y[n-19]^y[n-25]^y[n-26].
- History register hist[1:26], where hist[1] is the newest bit.
  - Prediction p = hist[18]^hist[19]^hist[25]^hist[26] (combinational).
- All state updates occur only on cycles with din_valid=1. With din_valid=0 every register holds and err_pulse=0.
- Reset (async, rst=1): state=HUNT, hist=0, fill=0, match_run=0, win_bits=0, win_errs=0, locked=0, err_pulse=0, err_cnt=0, bit_cnt=0.
- HUNT, per valid bit:
  - hist <= {din, hist[1:25]}.
  - If fill<26: fill++, match_run=0.
  - Else if din==p and hist!=0: match_run++.
    - When match_run reaches LOCK_CNT: go to LOCKED, locked=1 from the next cycle, win_bits=0, win_errs=0.
  - Else: match_run=0.
  - err_pulse stays 0; counters hold.
- LOCKED, per valid bit (flywheel):
  - hist <= {p, hist[1:25]}, so the received bit is NOT inserted and a single error cannot multiply.
  - err = (din!=p); err_pulse <= err, registered, one cycle after the sample.
  - err_cnt += err, saturating at all-ones.
  - bit_cnt += 1, saturating at all-ones.
  - win_bits++, win_errs += err.
  - If win_errs+err >= LOSS_THRESH: go to HUNT immediately.
    - fill=0, match_run=0, locked=0 next cycle.
    - err_pulse for that bit is still asserted; counters still update.
  - Else if win_bits+1 == WIN: win_bits=0, win_errs=0 (window end).
  - If hist becomes all-zero (cannot occur with a valid generator): go to HUNT as above.
- clr_cnt=1: err_cnt=0 and bit_cnt=0 next cycle.
  - It overrides any coincident increment.
  - It has no effect on state, hist, window counters, or err_pulse.
- Latency: locked/err_pulse/counter updates are visible one clock after the qualifying valid sample. There is no combinational path from inputs to outputs.
- Minimum lock acquisition from reset with a clean stream: 26 + LOCK_CNT valid bits (58 at defaults).
- Reset asserted mid-operation: all state returns to reset values asynchronously. After release, acquisition restarts from fill=0.

Test Plan:
- Clean lock:
  - Stimulus: bench generator seeded s=26'h0000001, continuous din_valid.
  - Required: locked rises exactly 1 clock after the 58th valid bit; err_cnt=0; bit_cnt increments 1/valid bit afterwards.
- Single flip:
  - Stimulus: lock, then invert one bit.
  - Required: exactly one err_pulse, 1 cycle after that bit; err_cnt=1; locked stays 1; subsequent bits error-free (no multiplication).
- Loss of lock:
  - Stimulus: after lock, invert 16 bits within one 256-bit window.
  - Required: locked falls 1 cycle after the 16th error; err_cnt=16; relock after a further 58 clean valid bits.
- Window rollover:
  - Stimulus: 15 errors in window 1, then 15 errors in window 2.
  - Required: locked stays 1; err_cnt=30.
- All-zero / gapped input:
  - Stimulus: 1000 zero bits.
  - Required: locked never asserts.
  - Stimulus: clean stream with random din_valid gaps (1..5 cycles).
  - Required: lock after 58 valid bits; no errors.
- Clear and reset:
  - Stimulus: clr_cnt coincident with an error bit.
  - Required: err_cnt=0 next cycle; err_pulse=1.
  - Stimulus: rst pulse while LOCKED.
  - Required: locked=0 and counters=0 immediately, without waiting for a clock edge.
